// File: rtl/opicorv32_decoder.sv
// Two-stage RV32I (+PicoRV32 custom/counter) instruction decoder.
// Stage A decodes the raw word; stage B adds ALU group flags and drives every output.
module opicorv32_decoder (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] fetch_word,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [47:0] instr,
  output logic [14:0] is,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [31:0] dec_imm,
  output logic        dec_illegal
);

  // Handshake: a word moves across an interface only in a cycle where
  // valid && ready; a stage with valid=1 holds its contents until then.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [47:0] d_instr;
  logic [31:0] d_imm;
  logic        fmt_i, fmt_sh, fmt_s, fmt_b, fmt_u, fmt_j;

  logic        a_valid;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [47:0] a_instr;
  logic [31:0] a_imm;
  logic        a_illegal;
  logic [14:0] a_is;

  logic        b_valid;
  logic        b_free;
  logic        a_advance;

  assign opcode = fetch_word[6:0];
  assign funct3 = fetch_word[14:12];
  assign funct7 = fetch_word[31:25];

  always_comb begin
    d_instr = '0;
    case (opcode)
      7'b0110111: d_instr[0] = 1'b1;
      7'b0010111: d_instr[1] = 1'b1;
      7'b1101111: d_instr[2] = 1'b1;
      7'b1100111: d_instr[3] = (funct3 == 3'b000);
      7'b1100011: begin
        case (funct3)
          3'b000:  d_instr[4] = 1'b1;
          3'b001:  d_instr[5] = 1'b1;
          3'b100:  d_instr[6] = 1'b1;
          3'b101:  d_instr[7] = 1'b1;
          3'b110:  d_instr[8] = 1'b1;
          3'b111:  d_instr[9] = 1'b1;
          default: ;
        endcase
      end
      7'b0000011: begin
        case (funct3)
          3'b000:  d_instr[10] = 1'b1;
          3'b001:  d_instr[11] = 1'b1;
          3'b010:  d_instr[12] = 1'b1;
          3'b100:  d_instr[13] = 1'b1;
          3'b101:  d_instr[14] = 1'b1;
          default: ;
        endcase
      end
      7'b0100011: begin
        case (funct3)
          3'b000:  d_instr[15] = 1'b1;
          3'b001:  d_instr[16] = 1'b1;
          3'b010:  d_instr[17] = 1'b1;
          default: ;
        endcase
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  d_instr[18] = 1'b1;
          3'b010:  d_instr[19] = 1'b1;
          3'b011:  d_instr[20] = 1'b1;
          3'b100:  d_instr[21] = 1'b1;
          3'b110:  d_instr[22] = 1'b1;
          3'b111:  d_instr[23] = 1'b1;
          3'b001:  d_instr[24] = (funct7 == 7'h00);
          3'b101: begin
            d_instr[25] = (funct7 == 7'h00);
            d_instr[26] = (funct7 == 7'h20);
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  d_instr[27] = 1'b1;
            3'b001:  d_instr[29] = 1'b1;
            3'b010:  d_instr[30] = 1'b1;
            3'b011:  d_instr[31] = 1'b1;
            3'b100:  d_instr[32] = 1'b1;
            3'b101:  d_instr[33] = 1'b1;
            3'b110:  d_instr[35] = 1'b1;
            3'b111:  d_instr[36] = 1'b1;
            default: ;
          endcase
        end else if (funct7 == 7'h20) begin
          d_instr[28] = (funct3 == 3'b000);
          d_instr[34] = (funct3 == 3'b101);
        end
      end
      7'b1110011: begin
        // Counter reads are CSRRS with rs1=x0; ecall/ebreak must match exactly.
        if (funct3 == 3'b010 && fetch_word[19:15] == 5'd0) begin
          case (fetch_word[31:20])
            12'hc00: d_instr[37] = 1'b1;
            12'hc80: d_instr[38] = 1'b1;
            12'hc02: d_instr[39] = 1'b1;
            12'hc82: d_instr[40] = 1'b1;
            default: ;
          endcase
        end
        d_instr[47] = (fetch_word == 32'h0000_0073) || (fetch_word == 32'h0010_0073);
      end
      7'b0001011: begin
        case (funct7)
          7'd0:    d_instr[41] = 1'b1;
          7'd1:    d_instr[42] = 1'b1;
          7'd2:    d_instr[43] = 1'b1;
          7'd3:    d_instr[44] = 1'b1;
          7'd4:    d_instr[45] = 1'b1;
          7'd5:    d_instr[46] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Immediate format follows the matched instruction, so unmatched words yield 0.
  assign fmt_u  = |d_instr[1:0];
  assign fmt_j  = d_instr[2];
  assign fmt_i  = d_instr[3] | (|d_instr[14:10]) | (|d_instr[23:18]);
  assign fmt_sh = |d_instr[26:24];
  assign fmt_s  = |d_instr[17:15];
  assign fmt_b  = |d_instr[9:4];

  always_comb begin
    d_imm = '0;
    if (fmt_u) begin
      d_imm = {fetch_word[31:12], 12'b0};
    end else if (fmt_j) begin
      d_imm = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20],
               fetch_word[30:21], 1'b0};
    end else if (fmt_i) begin
      d_imm = {{20{fetch_word[31]}}, fetch_word[31:20]};
    end else if (fmt_sh) begin
      d_imm = {27'b0, fetch_word[24:20]};
    end else if (fmt_s) begin
      d_imm = {{20{fetch_word[31]}}, fetch_word[31:25], fetch_word[11:7]};
    end else if (fmt_b) begin
      d_imm = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25],
               fetch_word[11:8], 1'b0};
    end
  end

  always_comb begin
    a_is     = '0;
    a_is[0]  = a_instr[0] | a_instr[1] | a_instr[2];
    a_is[1]  = |a_instr[14:10];
    a_is[2]  = |a_instr[26:24];
    a_is[3]  = a_instr[3] | (|a_instr[23:18]);
    a_is[4]  = |a_instr[17:15];
    a_is[5]  = a_instr[29] | a_instr[33] | a_instr[34];
    a_is[6]  = a_instr[0] | a_instr[1] | a_instr[2] | a_instr[3] | a_instr[18] | a_instr[27];
    a_is[7]  = a_instr[19] | a_instr[6] | a_instr[30];
    a_is[8]  = a_instr[20] | a_instr[8] | a_instr[31];
    a_is[9]  = |a_instr[9:4];
    a_is[10] = a_instr[13] | a_instr[14] | a_instr[12];
    a_is[11] = a_is[2] | a_is[3];
    a_is[12] = |a_instr[36:27];
    a_is[13] = a_instr[19] | a_instr[20] | a_instr[30] | a_instr[31];
    a_is[14] = |a_instr[40:37];
  end

  assign b_free      = !b_valid || dec_ready;
  assign a_advance   = a_valid && b_free;
  assign fetch_ready = !a_valid || a_advance;
  assign dec_valid   = b_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_valid   <= 1'b0;
      a_rd      <= '0;
      a_rs1     <= '0;
      a_rs2     <= '0;
      a_instr   <= '0;
      a_imm     <= '0;
      a_illegal <= 1'b0;
    end else if (fetch_ready) begin
      a_valid <= fetch_valid;
      if (fetch_valid) begin
        a_rd      <= fetch_word[11:7];
        a_rs1     <= fetch_word[19:15];
        a_rs2     <= fetch_word[24:20];
        a_instr   <= d_instr;
        a_imm     <= d_imm;
        a_illegal <= (d_instr == 48'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      b_valid     <= 1'b0;
      instr       <= '0;
      is          <= '0;
      dec_rd      <= '0;
      dec_rs1     <= '0;
      dec_rs2     <= '0;
      dec_imm     <= '0;
      dec_illegal <= 1'b0;
    end else if (b_free) begin
      b_valid <= a_valid;
      if (a_valid) begin
        instr       <= a_instr;
        is          <= a_is;
        dec_rd      <= a_rd;
        dec_rs1     <= a_rs1;
        dec_rs2     <= a_rs2;
        dec_imm     <= a_imm;
        dec_illegal <= a_illegal;
      end
    end
  end

endmodule

// File: tb/tb_opicorv32_decoder.sv
// Bench for opicorv32_decoder: directed vector table, stall/reset sequences,
// and random traffic scored against a pattern-table instruction model.
module tb_opicorv32_decoder;
  localparam int W = 111;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] fetch_word = '0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [47:0] instr;
  logic [14:0] is;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  always #5 clk = ~clk;

  opicorv32_decoder dut (
    .clk(clk), .resetn(resetn),
    .fetch_word(fetch_word), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr(instr), .is(is),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_illegal(dec_illegal)
  );

  typedef struct {
    logic [31:0] word;
    int          idx;
    logic [14:0] is_e;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;

  vec_t        vecs[17];
  logic [W-1:0] exp_q[$];
  logic [31:0] pat_mask[$];
  logic [31:0] pat_match[$];
  int          pat_idx[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic        popped, accepted, prev_hold = 1'b0;
  logic [W-1:0] pop_vec, prev_vec;

  function automatic logic [W-1:0] pack(input logic [47:0] i, input logic [14:0] s,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm,
                                        input logic ill);
    return {i, s, rd, rs1, rs2, imm, ill};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return pack(instr, is, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_illegal);
  endfunction

  task automatic add_pat(input logic [31:0] m, input logic [31:0] v, input int idx);
    pat_mask.push_back(m);
    pat_match.push_back(v);
    pat_idx.push_back(idx);
  endtask

  task automatic build_patterns();
    int bf3[6] = '{0, 1, 4, 5, 6, 7};
    int lf3[5] = '{0, 1, 2, 4, 5};
    int if3[6] = '{0, 2, 3, 4, 6, 7};
    int rf3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int rf7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    logic [31:0] csr[4] = '{32'hc00, 32'hc80, 32'hc02, 32'hc82};
    add_pat(32'h7f, 32'h37, 0);
    add_pat(32'h7f, 32'h17, 1);
    add_pat(32'h7f, 32'h6f, 2);
    add_pat(32'h707f, 32'h67, 3);
    for (int k = 0; k < 6; k++) add_pat(32'h707f, 32'h63 | (bf3[k] << 12), 4 + k);
    for (int k = 0; k < 5; k++) add_pat(32'h707f, 32'h03 | (lf3[k] << 12), 10 + k);
    for (int k = 0; k < 3; k++) add_pat(32'h707f, 32'h23 | (k << 12), 15 + k);
    for (int k = 0; k < 6; k++) add_pat(32'h707f, 32'h13 | (if3[k] << 12), 18 + k);
    add_pat(32'hfe00707f, 32'h00001013, 24);
    add_pat(32'hfe00707f, 32'h00005013, 25);
    add_pat(32'hfe00707f, 32'h40005013, 26);
    for (int k = 0; k < 10; k++)
      add_pat(32'hfe00707f, 32'h33 | (rf3[k] << 12) | (rf7[k] << 25), 27 + k);
    for (int k = 0; k < 4; k++) add_pat(32'hfffff07f, (csr[k] << 20) | 32'h2073, 37 + k);
    for (int k = 0; k < 6; k++) add_pat(32'hfe00007f, (k << 25) | 32'h0b, 41 + k);
    add_pat(32'hffffffff, 32'h00000073, 47);
    add_pat(32'hffffffff, 32'h00100073, 47);
  endtask

  // Reference: look the word up in the pattern table, then derive flags and immediate.
  function automatic logic [W-1:0] ref_vec(input logic [31:0] w);
    int idx = -1;
    logic [47:0] iv = '0;
    logic [14:0] s = '0;
    logic [31:0] imm = '0;
    logic [31:0] sx = {32{w[31]}};
    for (int k = 0; k < pat_mask.size(); k++)
      if ((w & pat_mask[k]) == pat_match[k]) idx = pat_idx[k];
    if (idx >= 0) iv[idx] = 1'b1;
    s[0]  = idx inside {0, 1, 2};
    s[1]  = idx inside {[10:14]};
    s[2]  = idx inside {[24:26]};
    s[3]  = idx inside {3, [18:23]};
    s[4]  = idx inside {[15:17]};
    s[5]  = idx inside {29, 33, 34};
    s[6]  = idx inside {0, 1, 2, 3, 18, 27};
    s[7]  = idx inside {19, 6, 30};
    s[8]  = idx inside {20, 8, 31};
    s[9]  = idx inside {[4:9]};
    s[10] = idx inside {12, 13, 14};
    s[11] = s[2] | s[3];
    s[12] = idx inside {[27:36]};
    s[13] = idx inside {19, 20, 30, 31};
    s[14] = idx inside {[37:40]};
    if (idx inside {0, 1}) imm = w & 32'hffff_f000;
    else if (idx == 2)
      imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    else if (idx inside {[24:26]}) imm = 32'(w[24:20]);
    else if (idx inside {3, [10:14], [18:23]}) imm = 32'($signed(w) >>> 20);
    else if (idx inside {[15:17]}) imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
    else if (idx inside {[4:9]})
      imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    return pack(iv, s, w[11:7], w[19:15], w[24:20], imm, idx < 0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic fv, input logic [31:0] fw, input logic dr);
    logic [W-1:0] cur;
    @(negedge clk);
    fetch_valid = fv;
    fetch_word  = fw;
    dec_ready   = dr;
    #1;
    cur = dut_vec();
    if (prev_hold) begin
      check("hold_valid", W'(dec_valid), W'(1));
      check("hold_data", cur, prev_vec);
    end
    accepted = fv && fetch_ready;
    if (accepted) exp_q.push_back(ref_vec(fw));
    popped = dec_valid && dr;
    if (popped) begin
      pops++;
      pop_vec = cur;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out: got %h expected no output", cur);
      end else begin
        check("out_data", cur, exp_q.pop_front());
      end
    end
    prev_hold = dec_valid && !dr;
    prev_vec  = cur;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    fetch_valid = 1'b0;
    dec_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", W'(dec_valid), W'(0));
    check("rst_outputs", dut_vec(), '0);
    check("rst_fetch_ready", W'(fetch_ready), W'(1));
    resetn = 1'b1;
    exp_q.delete();
    prev_hold = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    int k = $urandom_range(0, pat_mask.size());
    if (k == pat_mask.size()) return $urandom;
    return ($urandom & ~pat_mask[k]) | pat_match[k];
  endfunction

  initial begin
    logic [31:0] sw[4];
    logic [31:0] pend;
    logic [47:0] ei;
    int nxt, lat;
    logic fv, dr;

    vecs[0]  = '{32'h002081B3, 27, 15'h1040, 32'h00000000, 5'd3,  5'd1,  5'd2};
    vecs[1]  = '{32'hFFF32293, 19, 15'h2888, 32'hFFFFFFFF, 5'd5,  5'd6,  5'd31};
    vecs[2]  = '{32'h00208463, 4,  15'h0200, 32'h00000008, 5'd8,  5'd1,  5'd2};
    vecs[3]  = '{32'hFFFFFFFF, -1, 15'h0000, 32'h00000000, 5'd31, 5'd31, 5'd31};
    vecs[4]  = '{32'h123450B7, 0,  15'h0041, 32'h12345000, 5'd1,  5'd8,  5'd3};
    vecs[5]  = '{32'h40315093, 26, 15'h0804, 32'h00000003, 5'd1,  5'd2,  5'd3};
    vecs[6]  = '{32'h0020A623, 17, 15'h0010, 32'h0000000C, 5'd12, 5'd1,  5'd2};
    vecs[7]  = '{32'hC00020F3, 37, 15'h4000, 32'h00000000, 5'd1,  5'd0,  5'd0};
    vecs[8]  = '{32'h00100073, 47, 15'h0000, 32'h00000000, 5'd0,  5'd0,  5'd1};
    vecs[9]  = '{32'hFFDFF0EF, 2,  15'h0041, 32'hFFFFFFFC, 5'd1,  5'd31, 5'd29};
    vecs[10] = '{32'h402081B3, 28, 15'h1000, 32'h00000000, 5'd3,  5'd1,  5'd2};
    vecs[11] = '{32'h022081B3, -1, 15'h0000, 32'h00000000, 5'd3,  5'd1,  5'd2};
    vecs[12] = '{32'h0000010B, 41, 15'h0000, 32'h00000000, 5'd2,  5'd0,  5'd0};
    vecs[13] = '{32'h0A00000B, 46, 15'h0000, 32'h00000000, 5'd0,  5'd0,  5'd0};
    vecs[14] = '{32'h0C00000B, -1, 15'h0000, 32'h00000000, 5'd0,  5'd0,  5'd0};
    vecs[15] = '{32'h02009093, -1, 15'h0000, 32'h00000000, 5'd1,  5'd1,  5'd0};
    vecs[16] = '{32'hFFE35283, 14, 15'h0402, 32'hFFFFFFFE, 5'd5,  5'd6,  5'd30};
    build_patterns();

    do_reset();

    // Directed table: one word at a time, two-cycle latency.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, vecs[i].word, 1'b1);
      check($sformatf("vec%0d_accept", i), W'(accepted), W'(1));
      popped = 1'b0;
      lat = 0;
      for (int k = 0; k < 6 && !popped; k++) begin
        cycle(1'b0, 32'h0, 1'b1);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), W'(lat), W'(2));
      ei = '0;
      if (vecs[i].idx >= 0) ei[vecs[i].idx] = 1'b1;
      check($sformatf("vec%0d_out", i), popped ? pop_vec : '0,
            pack(ei, vecs[i].is_e, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                 vecs[i].imm, vecs[i].idx < 0));
    end

    // Stall: four words offered against a blocked consumer, then released.
    for (int i = 0; i < 4; i++) sw[i] = rand_word();
    nxt = 0;
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(nxt < 4, sw[nxt < 4 ? nxt : 0], 1'b0);
      if (accepted) nxt++;
    end
    check("stall_accepted", W'(nxt), W'(2));
    check("stall_fetch_ready", W'(fetch_ready), W'(0));
    check("stall_pops", W'(pops), W'(0));
    for (int c = 0; c < 4; c++) begin
      cycle(nxt < 4, sw[nxt < 4 ? nxt : 0], 1'b1);
      if (accepted) nxt++;
      check($sformatf("stream_pop%0d", c), W'(popped), W'(1));
    end
    check("stream_pops", W'(pops), W'(4));
    check("stream_drained", W'(exp_q.size()), W'(0));

    // Reset with two words in flight.
    cycle(1'b1, rand_word(), 1'b0);
    cycle(1'b1, rand_word(), 1'b0);
    do_reset();
    pops = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check("post_rst_idle", W'(dec_valid), W'(0));
    end
    cycle(1'b1, 32'h002081B3, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("post_rst_delivery", W'(pops), W'(1));

    // Random traffic with random valid/ready.
    pend = rand_word();
    for (int c = 0; c < 600; c++) begin
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      cycle(fv, pend, dr);
      if (accepted) pend = rand_word();
    end
    for (int c = 0; c < 10; c++) cycle(1'b0, 32'h0, 1'b1);
    check("final_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
